// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency ALU: grants one operation at a time,
// times the ALU with a down-counter and returns the result. Define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module alu_req_arbiter #(
  parameter int ALU_LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] op0,
  input  logic [3:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  input  logic [7:0] alu_result,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result,
  output logic       busy,
  output logic [3:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_start,
  output logic [1:0] state_dbg
);

  // Handshake: reqN is a level; a grant needs reqN high with its rearm flag set, and the
  // flag only returns after reqN is seen low, so holding reqN high yields exactly one operation.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last, served, rearm0, rearm1;
  logic       elig0, elig1, win, grant, capture;

  assign elig0     = req0 & rearm0;
  assign elig1     = req1 & rearm1;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    win = 1'b0;
`ifdef ALU_ARB_FIXED_PRIO_EN
    win = ~elig0;
`else
    // On a tie the requester not served last wins.
    if (elig0 && elig1) win = ~last;
    else                win = ~elig0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (elig0 || elig1) begin
          state_nxt = EXEC;
          cnt_nxt   = LAT_M1;
          grant     = 1'b1;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
          capture   = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      alu_start  <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result     <= 8'd0;
      alu_opcode <= 4'd0;
      alu_a      <= 8'd0;
      alu_b      <= 8'd0;
      last       <= 1'b1;
      served     <= 1'b0;
      rearm0     <= 1'b1;
      rearm1     <= 1'b1;
    end else begin
      gnt0      <= grant & ~win;
      gnt1      <= grant & win;
      alu_start <= grant;
      done0     <= capture & ~served;
      done1     <= capture & served;
      if (grant) begin
        alu_opcode <= win ? op1 : op0;
        alu_a      <= win ? a1 : a0;
        alu_b      <= win ? b1 : b0;
        served     <= win;
        last       <= win;
      end
      if (capture) result <= alu_result;
      if (!req0)                 rearm0 <= 1'b1;
      else if (grant && !win)    rearm0 <= 1'b0;
      if (!req1)                 rearm1 <= 1'b1;
      else if (grant && win)     rearm1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: cycle-stamped transaction model, per-cycle compare and directed vectors.
`timescale 1ns/1ps
module tb_alu_req_arbiter;
  localparam int L = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] op0 = 4'd0, op1 = 4'd0;
  logic [7:0] a0 = 8'd0, b0 = 8'd0, a1 = 8'd0, b1 = 8'd0;
  logic [7:0] alu_result, result, alu_a, alu_b;
  logic [3:0] alu_opcode;
  logic       gnt0, gnt1, done0, done1, busy, alu_start;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h3:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic void chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  always #5 clk = ~clk;

  assign alu_result = alu_f(alu_opcode, alu_a, alu_b);

  alu_req_arbiter #(.ALU_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .alu_result(alu_result),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .result(result), .busy(busy),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start),
    .state_dbg(state_dbg)
  );

  // Latency-corner instances, exercised only by requester 0 with fixed operands.
  logic       rq_l1 = 1'b0, rq_l15 = 1'b0;
  logic [7:0] l1_res, l1_result, l1_a, l1_b, l15_res, l15_result, l15_a, l15_b;
  logic [3:0] l1_opc, l15_opc;
  logic       l1_gnt0, l1_gnt1, l1_done0, l1_done1, l1_busy, l1_start;
  logic       l15_gnt0, l15_gnt1, l15_done0, l15_done1, l15_busy, l15_start;
  logic [1:0] l1_st, l15_st;

  assign l1_res  = alu_f(l1_opc, l1_a, l1_b);
  assign l15_res = alu_f(l15_opc, l15_a, l15_b);

  alu_req_arbiter #(.ALU_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req0(rq_l1), .req1(1'b0), .op0(4'h2), .op1(4'h0),
    .a0(8'h20), .b0(8'h07), .a1(8'h00), .b1(8'h00), .alu_result(l1_res),
    .gnt0(l1_gnt0), .gnt1(l1_gnt1), .done0(l1_done0), .done1(l1_done1), .result(l1_result),
    .busy(l1_busy), .alu_opcode(l1_opc), .alu_a(l1_a), .alu_b(l1_b), .alu_start(l1_start),
    .state_dbg(l1_st)
  );

  alu_req_arbiter #(.ALU_LATENCY(15)) u_l15 (
    .clk(clk), .reset(reset), .req0(rq_l15), .req1(1'b0), .op0(4'h2), .op1(4'h0),
    .a0(8'h20), .b0(8'h07), .a1(8'h00), .b1(8'h00), .alu_result(l15_res),
    .gnt0(l15_gnt0), .gnt1(l15_gnt1), .done0(l15_done0), .done1(l15_done1), .result(l15_result),
    .busy(l15_busy), .alu_opcode(l15_opc), .alu_a(l15_a), .alu_b(l15_b), .alu_start(l15_start),
    .state_dbg(l15_st)
  );

  // Model: each accepted operation is a record of the cycle it is granted and the cycle it completes.
  int         cyc = 0, m_gnt_cyc = -1, m_done_cyc = -1, m_free_from = 0;
  logic       m_win = 1'b0, m_last = 1'b1;
  logic [1:0] m_rearm = 2'b11;
  logic [3:0] m_op = 4'd0;
  logic [7:0] m_a = 8'd0, m_b = 8'd0, m_result = 8'd0;
  logic [7:0] exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_gnt_cyc   <= -1;
      m_done_cyc  <= -1;
      m_free_from <= cyc;
      m_win       <= 1'b0;
      m_last      <= 1'b1;
      m_rearm     <= 2'b11;
      m_op        <= 4'd0;
      m_a         <= 8'd0;
      m_b         <= 8'd0;
      m_result    <= 8'd0;
      exp_q.delete();
    end else begin
      int   c;
      logic e0, e1, w;
      c  = cyc;
      e0 = req0 && m_rearm[0];
      e1 = req1 && m_rearm[1];
      cyc <= cyc + 1;
      if (c == m_done_cyc - 1) m_result <= alu_f(m_op, m_a, m_b);
      if (c >= m_free_from && (e0 || e1)) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        w = !e0;
`else
        w = (e0 && e1) ? !m_last : e1;
`endif
        m_win       <= w;
        m_last      <= w;
        m_gnt_cyc   <= c + 1;
        m_done_cyc  <= c + 1 + L;
        m_free_from <= c + L + 2;
        m_op        <= w ? op1 : op0;
        m_a         <= w ? a1 : a0;
        m_b         <= w ? b1 : b0;
        exp_q.push_back(w ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0));
        m_rearm[w]  <= 1'b0;
      end
      if (!req0) m_rearm[0] <= 1'b1;
      if (!req1) m_rearm[1] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      int k;
      k = cyc;
      chk_bit("gnt0", gnt0, k == m_gnt_cyc && !m_win);
      chk_bit("gnt1", gnt1, k == m_gnt_cyc && m_win);
      chk_bit("alu_start", alu_start, k == m_gnt_cyc);
      chk_bit("done0", done0, k == m_done_cyc && !m_win);
      chk_bit("done1", done1, k == m_done_cyc && m_win);
      chk_bit("busy", busy, k >= m_gnt_cyc && k <= m_done_cyc);
      chk_byte("result", result, m_result);
      chk_byte("alu_opcode", {4'd0, alu_opcode}, {4'd0, m_op});
      chk_byte("alu_a", alu_a, m_a);
      chk_byte("alu_b", alu_b, m_b);
      if (done0 || done1) begin
        if (exp_q.size() == 0) chk_bit("done_expected", 1'b1, 1'b0);
        else chk_byte("done_result", result, exp_q.pop_front());
      end
    end
  end

  // Waits for the next done pulse; reports the granted requester and negedges elapsed.
  task automatic run_op(output int win, output int lat);
    win = -1;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat = i + 1;
      if (gnt0) win = 0;
      if (gnt1) win = 1;
      if (done0 || done1) return;
    end
    chk_bit("run_op_timeout", 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int w, lat, cnt;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_bit("rst_gnt0", gnt0, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_start", alu_start, 1'b0);
    chk_bit("rst_done0", done0, 1'b0);
    chk_byte("rst_result", result, 8'h00);
    chk_byte("rst_alu_a", alu_a, 8'h00);
    reset = 1'b0;

    // Single op 5+3, then drop req0 and change A0 after the grant.
    req0 = 1'b1; op0 = 4'h2; a0 = 8'h05; b0 = 8'h03;
    @(negedge clk);
    chk_bit("c1_gnt0", gnt0, 1'b1);
    chk_bit("c1_start", alu_start, 1'b1);
    chk_byte("c1_alu_a", alu_a, 8'h05);
    req0 = 1'b0; a0 = 8'hff;
    @(negedge clk);
    chk_bit("c2_gnt0", gnt0, 1'b0);
    chk_byte("c2_alu_a", alu_a, 8'h05);
    @(negedge clk);
    chk_bit("c3_done0", done0, 1'b1);
    chk_byte("c3_result", result, 8'h08);

    // Ties from reset, each requester re-armed by one low cycle between operations.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req0 = 1'b1; op0 = 4'h2; a0 = 8'h10 + 8'(i); b0 = 8'h01;
      req1 = 1'b1; op1 = 4'h3; a1 = 8'h40; b1 = 8'(i);
      run_op(w, lat);
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk_int("tie_winner", w, 0);
`else
      chk_int("tie_winner", w, i % 2);
`endif
      chk_int("tie_latency", lat, L + 1);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
    end

    // Held request is served once; a low cycle re-arms it.
    do_reset();
    req1 = 1'b1; op1 = 4'h1; a1 = 8'hf0; b1 = 8'h0f;
    run_op(w, lat);
    chk_int("hold_first", w, 1);
    chk_byte("hold_result", result, 8'hff);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (gnt1) cnt++;
    end
    chk_int("hold_no_regrant", cnt, 0);
    req1 = 1'b0;
    @(negedge clk);
    req1 = 1'b1;
    run_op(w, lat);
    chk_int("rearm_grant", w, 1);
    chk_int("rearm_latency", lat, L + 1);

    // Asynchronous reset in the middle of EXEC.
    req1 = 1'b0;
    req0 = 1'b1; op0 = 4'h4; a0 = 8'h3c; b0 = 8'h0f;
    for (int i = 0; i < 5 && !gnt0; i++) @(negedge clk);
    chk_bit("mid_gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_bit("arst_busy", busy, 1'b0);
    chk_byte("arst_alu_a", alu_a, 8'h00);
    chk_byte("arst_alu_b", alu_b, 8'h00);
    chk_byte("arst_opcode", {4'd0, alu_opcode}, 8'h00);
    chk_byte("arst_result", result, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done0 || done1) cnt++;
    end
    chk_int("arst_no_done", cnt, 0);
    req0 = 1'b1;
    run_op(w, lat);
    chk_int("post_rst_winner", w, 0);
    chk_byte("post_rst_result", result, 8'h33);
    req0 = 1'b0;
    @(negedge clk);

    // Latency corners: done exactly 2 and 16 cycles after the sampling edge.
    rq_l1 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (l1_gnt0) rq_l1 = 1'b0;
      if (l1_done0) break;
    end
    chk_int("lat1_cycles", cnt, 2);
    chk_byte("lat1_result", l1_result, 8'h27);
    rq_l15 = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cnt++;
      if (l15_gnt0) rq_l15 = 1'b0;
      if (l15_done0) break;
    end
    chk_int("lat15_cycles", cnt, 16);
    chk_byte("lat15_result", l15_result, 8'h27);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
